rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Eight-requester round-robin arbiter with grant locking.
- Sits directly upstream of the 8-to-3 encoder stage and drives its 8-bit input with a registered one-hot grant, or all-zero when idle.
- The encoder turns the grant into a 3-bit requester index.
- The block guarantees the downstream encoder never sees more than one bit set.

Parameters:
- N, 8, number of requesters; fixed at 8 for the encoder pairing.
- IDX_W, 3, width of the internal rotation pointer (log2 N).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines, one per requester; level-sensitive.
- gnt  output  8  registered grant; one-hot or all-zero; feeds the encoder input d.
- gnt_valid  output  1  registered; high when gnt is non-zero.

Behaviour:
- Reset (async, rst=1): gnt=8'b0, gnt_valid=0, ptr=0, state=IDLE, hold counter=0. Outputs stay at these values while rst is high, regardless of req or clk.
- State IDLE, req==0: stay IDLE, gnt=0.
- State IDLE, req!=0: at the next rising edge, gnt = one-hot of the first set req bit searching upward from ptr with wrap 7->0. State becomes GRANT, ptr = winner+1 mod 8. Latency is 1 cycle from req sampled to gnt.
- State GRANT, req[owner]==1: hold gnt unchanged (lock). Other requests wait.
- State GRANT, req[owner]==0, other req bits set: at the next edge, grant the next winner searching from ptr with the owner bit excluded. No idle bubble. Stay in GRANT and update ptr.
- State GRANT, req[owner]==0, no other req: at the next edge, gnt=0, state=IDLE. ptr is retained.
- Search order: ptr, ptr+1, ... ptr+7, all mod 8. ptr=0 after reset gives bit0 priority on the first arbitration.
- Wrap: owner 7 gives ptr=0. Owner 3 gives ptr=4.
- Simultaneous requests: exactly one winner per the search order, never two bits set.
- A request asserted and dropped between edges is not seen; no latching of pulses.
- Owner drop and a new request on the same cycle: the new request competes in that cycle's search.
- Reset mid-grant: gnt drops to 0 immediately (asynchronous). After release, arbitration restarts from ptr=0.
- gnt_valid equals |gnt at all times; both are registered on the same edge.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: a hold counter increments each GRANT cycle and resets to 0 on every new grant. When the counter reaches MAX_HOLD-1 and any other req bit is set, the owner is pre-empted and the next winner is granted on the following edge even though req[owner] is still high. If no other request is pending, the owner keeps the grant and the counter saturates.
- Undefined: no counter is built and the owner holds the grant indefinitely while its req stays high.

Decomposition:
- Shared package arb_pkg: N, IDX_W, MAX_HOLD defaults, state encoding (IDLE=1'b0, GRANT=1'b1).
- One natural sub-module, rr_pick: purely combinational.
  - Inputs: req, ptr, exclude mask.
  - Outputs: one-hot winner and any_valid.
  - Implemented as a double-width rotate and priority find.
- rr_arbiter8 holds the FSM, ptr, grant registers and the optional counter.

Test Plan:
- Reset: assert rst with req=8'hFF mid-grant -> gnt=8'h00 and gnt_valid=0 immediately. After release, the first grant is 8'b00000001.
- Single request: req=8'b00010000 from IDLE -> gnt=8'b00010000 one edge later. Hold req for 5 cycles -> gnt unchanged. Drop req -> gnt=0 next edge.
- Rotation: req=8'hFF, release the owner each cycle -> grant sequence 01,02,04,08,10,20,40,80,01 (hex, one-hot). This checks the 7->0 wrap.
- Back-to-back handoff: owner bit2 drops while req=8'b10000001 -> next gnt=8'b10000000 (ptr=3), with no zero cycle in between.
- Invariant: random req for 10000 cycles -> gnt is always one-hot or zero, and gnt_valid == |gnt. An encoder instance on gnt never sees an illegal code.
- ARB_TIMEOUT_EN with MAX_HOLD=4: bit0 held, req=8'b00000011 -> gnt switches to 8'b00000010 after 4 grant cycles. With req=8'b00000001 only, bit0 keeps the grant.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared sizing constants and FSM state encoding for the
//               eight-requester round-robin arbiter and its picker.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Requester count; fixed at 8 to pair with the 8-to-3 encoder stage.
  localparam int N = 8;

  // Rotation pointer width, log2(N).
  localparam int IDX_W = 3;

  // Default owner hold limit when the timeout feature is built.
  localparam int MAX_HOLD_DEFAULT = 16;

  // Arbiter FSM encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Masks out excluded bits,
//               rotates the request vector so that bit ptr sits at position
//               0 (double-width concatenate and shift), takes the lowest set
//               bit, and maps that offset back to an absolute index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic [N-1:0]     i_excl,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any_valid
);

  logic [N-1:0]     w_masked;
  logic [2*N-1:0]   w_double;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic             w_found;

  assign w_masked = i_req & ~i_excl;
  assign w_double = {w_masked, w_masked};

  // After the shift, bit k of w_rot is request (ptr + k) mod N.
  assign w_rot = N'(w_double >> i_ptr);

  // Priority find: lowest set bit of the rotated vector is the nearest
  // requester at or after ptr. Scanning downward lets the lowest hit win.
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = k[IDX_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  // Offset back to absolute index; IDX_W-bit addition wraps 7 -> 0.
  assign o_idx       = i_ptr + w_off;
  assign o_onehot    = w_found ? ({{(N-1){1'b0}}, 1'b1} << o_idx) : '0;
  assign o_any_valid = |w_masked;

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : Eight-requester round-robin arbiter with grant locking.
//               Drives a registered one-hot (or all-zero) grant into the
//               downstream 8-to-3 encoder. The owner keeps the grant while
//               its request stays high; on release the next requester after
//               the rotation pointer takes over without an idle bubble.
//               Optional macro ARB_TIMEOUT_EN adds a hold counter that
//               pre-empts an owner after MAX_HOLD cycles when others wait.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid
);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     r_gnt;
  logic             r_gnt_valid;

  logic [0:0]       w_next_state;
  logic [IDX_W-1:0] w_next_ptr;
  logic [N-1:0]     w_next_gnt;
  logic [N-1:0]     w_pick_onehot;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic             w_owner_req;
  logic             w_preempt;

  // The current owner is always excluded from the search, so a hand-off can
  // never re-select the requester that just released. In IDLE r_gnt is zero
  // and nothing is excluded.
  rr_pick u_pick (
    .i_req       (req),
    .i_ptr       (r_ptr),
    .i_excl      (r_gnt),
    .o_onehot    (w_pick_onehot),
    .o_idx       (w_pick_idx),
    .o_any_valid (w_pick_valid)
  );

  assign w_owner_req = |(req & r_gnt);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              w_hold_last;
  logic              w_new_grant;

  assign w_hold_last = (r_hold == C_HOLD_LAST);
  assign w_new_grant = (w_next_gnt != r_gnt) && (|w_next_gnt);

  // Pre-empt only when the limit is hit and some other requester is waiting;
  // a lone owner keeps the grant with the counter saturated.
  assign w_preempt = (r_state == ST_GRANT) && w_hold_last && w_pick_valid;

  // Hold counter: cleared on every new grant, counts owner cycles, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_new_grant || (w_next_state == ST_IDLE)) begin
      r_hold <= '0;
    end else if ((r_state == ST_GRANT) && !w_hold_last) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  // Next-state decode: lock, hand off, go idle, or start a new grant.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    w_next_gnt   = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_next_state = ST_GRANT;
          w_next_gnt   = w_pick_onehot;
          w_next_ptr   = w_pick_idx + IDX_W'(1);
        end
      end
      ST_GRANT: begin
        if (w_owner_req && !w_preempt) begin
          w_next_gnt = r_gnt;
        end else if (w_pick_valid) begin
          w_next_gnt = w_pick_onehot;
          w_next_ptr = w_pick_idx + IDX_W'(1);
        end else begin
          w_next_state = ST_IDLE;
          w_next_gnt   = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_gnt   = '0;
      end
    endcase
  end

  // State, pointer and grant registers; gnt_valid is registered alongside gnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ptr       <= w_next_ptr;
      r_gnt       <= w_next_gnt;
      r_gnt_valid <= |w_next_gnt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;

  // The encoder downstream relies on gnt never carrying two set bits.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));

endmodule : rr_arbiter8
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Scoreboard bench for rr_arbiter8. Stimulus pushes expected
//               grants into a queue; a monitor pops and compares after each
//               rising edge. Directed phases use fixed expectations, the
//               random phase uses a behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;
  import arb_pkg::*;

  localparam int TB_MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic       gnt_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  // Reference model state: owner index (-1 = none), pointer, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // Behavioural arbiter: returns the grant expected after the next edge.
  task automatic model_step(input logic [7:0] r, output logic [7:0] e);
    bit keep;
    bit others;
    int win;
    others = 0;
    for (int i = 0; i < 8; i++) if (r[i] && i != m_owner) others = 1;
    keep = (m_owner >= 0) && r[m_owner];
`ifdef ARB_TIMEOUT_EN
    if (keep && others && m_hold == TB_MAX_HOLD - 1) keep = 0;
`endif
    if (keep) begin
      if (m_hold < TB_MAX_HOLD - 1) m_hold++;
    end else begin
      win = -1;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (win < 0 && r[idx] && idx != m_owner) win = idx;
      end
      if (win >= 0) begin
        m_owner = win;
        m_ptr   = (win + 1) % 8;
      end else begin
        m_owner = -1;
      end
      m_hold = 0;
    end
    e = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
  endtask

  // Called at a falling edge: drive req, queue expectation, move to next fall.
  task automatic step(input logic [7:0] r, input bit use_fixed, input logic [7:0] fixed_e);
    logic [7:0] e;
    req = r;
    model_step(r, e);
    exp_q.push_back(use_fixed ? fixed_e : e);
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [7:0] e);
    total++;
    if (gnt !== e || gnt_valid !== (e != 8'h00)) begin
      bad++;
      $display("FAIL %s: got gnt=%02h valid=%0b, expected gnt=%02h valid=%0b",
               name, gnt, gnt_valid, e, (e != 8'h00));
    end
  endtask

  // Monitor: invariant plus scoreboard pop after every edge out of reset.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      total++;
      if (!$onehot0(gnt) || gnt_valid !== (|gnt)) begin
        bad++;
        $display("FAIL invariant: got gnt=%02h valid=%0b, expected one-hot/zero with valid=|gnt",
                 gnt, gnt_valid);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        total++;
        if (gnt !== mon_e || gnt_valid !== (mon_e != 8'h00)) begin
          bad++;
          $display("FAIL scoreboard: got gnt=%02h valid=%0b, expected gnt=%02h valid=%0b",
                   gnt, gnt_valid, mon_e, (mon_e != 8'h00));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rv;
    logic [7:0] rot_req [9];
    logic [7:0] rot_exp [9];
    rot_req = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    rot_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    // Reset state.
    repeat (3) @(negedge clk);
    check_now("reset_state", 8'h00);
    req = 8'hFF;
    @(negedge clk);
    check_now("reset_hold_req", 8'h00);
    rst = 1'b0;

    // Rotation with owner release every cycle, including 7 -> 0 wrap.
    for (int i = 0; i < 9; i++) step(rot_req[i], 1, rot_exp[i]);
    step(8'h00, 1, 8'h00);

    // Single request: grant, lock for 5 cycles, release.
    step(8'h10, 1, 8'h10);
    repeat (5) step(8'h10, 1, 8'h10);
    step(8'h00, 1, 8'h00);

    // Back-to-back hand-off: owner 2 releases while 7 and 0 wait, ptr=3.
    step(8'h04, 1, 8'h04);
    step(8'h81, 1, 8'h80);
    step(8'h00, 1, 8'h00);

    // Hold limit: bit0 owns with bit1 waiting.
    repeat (4) step(8'h03, 1, 8'h01);
`ifdef ARB_TIMEOUT_EN
    step(8'h03, 1, 8'h02);
`else
    step(8'h03, 1, 8'h01);
`endif
    step(8'h00, 1, 8'h00);
    // Lone owner keeps the grant past the limit.
    repeat (8) step(8'h01, 1, 8'h01);

    // Asynchronous reset mid-grant with all requests high.
    req = 8'hFF;
    #2 rst = 1'b1;
    #1 check_now("reset_async", 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1 check_now("reset_held", 8'h00);
    end
    @(negedge clk);
    rst     = 1'b0;
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    step(8'hFF, 1, 8'h01);

    // Random traffic against the reference model.
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = 8'($urandom);
        1:       rv = 8'($urandom & $urandom);
        2:       rv = 8'($urandom & $urandom & $urandom);
        default: rv = req;
      endcase
      step(rv, 0, 8'h00);
    end

    // Drain and confirm every expectation was consumed.
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_arbiter8
`default_nettype wire
